// File: rtl/ram_stream_reader_if.sv
// Bundles the control, RAM port-B and output stream signals of the stream reader.
// The master modport is the reader's view. The slave modport is the controller, RAM and sink view.
interface ram_stream_reader_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   length;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_blk_n;
    logic                  ram_wen_n;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        input  start, base_addr, length, ram_dout, dout_ready,
        output busy, done, ram_addr, ram_blk_n, ram_wen_n, dout, dout_valid
    );

    modport slave (
        output start, base_addr, length, ram_dout, dout_ready,
        input  busy, done, ram_addr, ram_blk_n, ram_wen_n, dout, dout_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Read-side burst engine for a RAM4K9 buffer.
// It issues port-B reads from base_addr for length words and tracks the RAM latency
// with a valid shift register. Returned words land in a 4-entry FIFO. Credits
// (in-flight plus buffered words) are capped at 4, so backpressure never drops data.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 9,
    parameter int PIPE       = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    ram_stream_reader_if.master bus
);
    localparam int LW     = ADDR_WIDTH + 1;
    localparam int STAGES = PIPE + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         w_len_nxt;
    logic [LW-1:0]         r_issued;
    logic [LW-1:0]         w_issued_nxt;
    logic [LW-1:0]         r_accepted;
    logic [LW-1:0]         w_accepted_nxt;
    logic [PIPE:0]         r_infl;
    logic [DATA_WIDTH-1:0] r_mem [4];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic [2:0]            w_credit;
    logic                  w_issue;
    logic                  w_fifo_wr;
    logic                  w_fifo_full;
    logic                  w_pop;
    logic                  w_done;

    // Number of reads still travelling through the RAM pipeline
    function automatic logic [2:0] f_popcount(input logic [PIPE:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i <= PIPE; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    assign w_credit    = f_popcount(r_infl) + r_count;
    assign w_issue     = (r_state == ST_RUN) && (r_issued != r_len) && (w_credit < 3'd4);
    assign w_fifo_wr   = r_infl[PIPE];
    assign w_fifo_full = (r_count == 3'd4);
    assign w_pop       = (r_count != 3'd0) && bus.dout_ready;
    assign w_done      = (r_state == ST_DRAIN) && (r_accepted == r_len);

    // Next-state, address and burst counter computation
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_len_nxt      = r_len;
        w_issued_nxt   = r_issued;
        w_accepted_nxt = r_accepted;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_len_nxt      = bus.length;
                    w_addr_nxt     = bus.base_addr;
                    w_issued_nxt   = {LW{1'b0}};
                    w_accepted_nxt = {LW{1'b0}};
                    if (bus.length == {LW{1'b0}}) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_issue) begin
                    w_addr_nxt   = r_addr + ADDR_WIDTH'(1);
                    w_issued_nxt = r_issued + LW'(1);
                end else begin
                    w_addr_nxt   = r_addr;
                    w_issued_nxt = r_issued;
                end
                if (w_pop) begin
                    w_accepted_nxt = r_accepted + LW'(1);
                end else begin
                    w_accepted_nxt = r_accepted;
                end
                if (w_issued_nxt == r_len) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_pop) begin
                    w_accepted_nxt = r_accepted + LW'(1);
                end else begin
                    w_accepted_nxt = r_accepted;
                end
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, address and burst counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= {ADDR_WIDTH{1'b0}};
            r_len      <= {LW{1'b0}};
            r_issued   <= {LW{1'b0}};
            r_accepted <= {LW{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_len      <= w_len_nxt;
            r_issued   <= w_issued_nxt;
            r_accepted <= w_accepted_nxt;
        end
    end

    // Valid shift register mirroring the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_infl <= {STAGES{1'b0}};
        end else begin
            r_infl <= (r_infl << 1) | STAGES'(w_issue);
        end
    end

    // Output FIFO: capture returning RAM data and pop on stream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_fifo_wr) begin
                r_mem[r_wr_ptr] <= bus.ram_dout;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = w_done;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_blk_n  = ~w_issue;
    assign bus.ram_wen_n  = 1'b1;
    assign bus.dout       = r_mem[r_rd_ptr];
    assign bus.dout_valid = (r_count != 3'd0);

    ram_stream_reader_chk u_chk (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_fifo_wr   (w_fifo_wr),
        .i_fifo_full (w_fifo_full)
    );
endmodule

// Checks that the credit scheme never lets returning data hit a full FIFO.
module ram_stream_reader_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_fifo_wr,
    input logic i_fifo_full
);
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    !(i_fifo_wr && i_fifo_full));
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side engine for a RAM4K9-based buffer. It drives the read port (port B) of the block RAM and fetches a programmed burst of words starting at a base address.
- Words are delivered on a valid/ready stream. A 4-entry output buffer absorbs the RAM read latency, so backpressure never loses a word.
- Sits opposite the writer that fills port A; used by monitor blocks to drain captured sample buffers.

Parameters:
- ADDR_WIDTH, 9, RAM word address width (512 x 9 configuration).
- DATA_WIDTH, 9, RAM word width.
- PIPE, 0, RAM read latency select, matching the RAM PIPEB tie-off: 0 gives 1 cycle from address to data, 1 gives 2 cycles.

Ports:
- clk  input  1  system clock; RAM CLKB is driven from the same net.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only when busy=0.
- base_addr  input  ADDR_WIDTH  first word address, captured on start.
- length  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH, captured on start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the last word has been accepted downstream.
- ram_addr  output  ADDR_WIDTH  port-B address.
- ram_blk_n  output  1  port-B block select, active low; 0 only in cycles that issue a read.
- ram_wen_n  output  1  port-B write enable, active low; constant 1 (read only).
- ram_dout  input  DATA_WIDTH  port-B read data.
- dout  output  DATA_WIDTH  stream data.
- dout_valid  output  1  stream valid.
- dout_ready  input  1  stream ready; a transfer occurs when valid and ready are both high.

Behaviour:
- Reset values: busy=0, done=0, ram_addr=0, ram_blk_n=1, ram_wen_n=1, dout=0, dout_valid=0. Internal counters, the in-flight shift register and the buffer are all cleared.
- State machine: IDLE -> RUN on start, with the length and base address captured. RUN -> DRAIN when the issued count reaches length. DRAIN -> IDLE when the accepted count reaches length; done pulses in that transition cycle. start with length=0 goes IDLE -> DRAIN -> IDLE, with done pulsing 1 cycle after start and no RAM access.
- Read issue happens in RUN when in_flight + buf_count < 4:
  - ram_blk_n=0 and ram_addr=current address.
  - The address then increments modulo 2^ADDR_WIDTH, so a burst crossing the top wraps to 0.
  - The issued count increments.
- In-flight tracking: a (1+PIPE)-stage valid shift register mirrors RAM latency. When a stage exits, ram_dout is written into the 4-entry FIFO. Credit accounting guarantees the FIFO never overflows; a write to a full FIFO is a design error, flagged by a simulation assertion.
- Output:
  - dout/dout_valid come from the FIFO head.
  - Data appears at the earliest 1 cycle after the RAM data-valid cycle (registered FIFO output).
  - The head pops on valid&&ready.
  - dout holds while valid=1 and ready=0.
- Throughput: sustains 1 word/cycle with dout_ready held high, for both PIPE settings.
- First-word latency from start to dout_valid is 3+PIPE cycles: start capture, issue, RAM latency, FIFO register.
- busy stays high during DRAIN until the final handshake; start asserted while busy=1 is ignored.
- A simultaneous FIFO write and pop in one cycle leaves the count unchanged; both occur.
- rst_n asserted mid-burst aborts immediately: outputs return to reset values, no done pulse is produced, and buffered data is discarded.
- Max length 2^ADDR_WIDTH reads every word exactly once, starting at base_addr.

Test Plan:
- PIPE=0, base=0x010, length=8, ready=1 -> dout = mem[0x010..0x017] on 8 consecutive cycles, first valid 3 cycles after start, done 1 cycle after the 8th transfer.
- PIPE=1, base=0x1FE, length=4 -> ram_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; dout = mem of those addresses in order.
- length=16, dout_ready toggling 1/0 every cycle, then low for 10 cycles mid-burst -> no words lost or duplicated; ram_blk_n stays 1 once 4 words are outstanding or buffered; dout stable while stalled.
- length=0 -> done pulses 1 cycle after start, ram_blk_n never 0, dout_valid never 1.
- Second start pulsed during busy -> ignored; the burst completes with the original length. A start the cycle after done is accepted.
- rst_n pulled low after 5 of 12 words -> busy=0, dout_valid=0, ram_blk_n=1 asynchronously, no done. A new burst after release returns correct data.
